// File: rtl/kernel_kcore_start_fork_fifo.sv
// rtl/kernel_kcore_start_fork_fifo.sv - multi-consumer start-token FIFO with shared shift register
module kernel_kcore_start_fork_fifo #(
  parameter int DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 2,
  parameter int DEPTH        = 4,
  parameter int NCH          = 2,
  parameter int AFULL_THRESH = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            if_write_ce,
  input  logic                            if_write,
  input  logic [DATA_WIDTH-1:0]           if_din,
  output logic                            if_full_n,
  output logic                            if_almost_full,
  input  logic [NCH-1:0]                  if_read_ce,
  input  logic [NCH-1:0]                  if_read,
  output logic [NCH-1:0]                  if_empty_n,
  output logic [NCH*DATA_WIDTH-1:0]       if_dout,
  input  logic [NCH-1:0]                  chan_en,
  output logic [NCH*(ADDR_WIDTH+1)-1:0]   if_count
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [CW-1:0]         count_q [NCH];
  logic [CW-1:0]         count_d [NCH];
  logic [NCH-1:0]        empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  afull_q, afull_d;
  logic                  wr_en;
  logic [NCH-1:0]        rd_en;

  assign wr_en = if_write & if_write_ce & full_n_q;
  assign rd_en = if_read & if_read_ce & empty_n_q & chan_en;

  // Disabled channels are forced to zero, so flag reduction can look at every channel.
  always_comb begin
    full_n_d  = 1'b1;
    afull_d   = 1'b0;
    empty_n_d = '0;
    for (int k = 0; k < NCH; k++) begin
      count_d[k] = '0;
      if (chan_en[k]) begin
        count_d[k] = count_q[k] + CW'(wr_en) - CW'(rd_en[k]);
      end
      empty_n_d[k] = (count_d[k] != '0);
      if (count_d[k] == CW'(DEPTH)) full_n_d = 1'b0;
      if (count_d[k] >= CW'(AFULL_THRESH)) afull_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) count_q[k] <= '0;
      empty_n_q <= '0;
      full_n_q  <= 1'b1;
      afull_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) count_q[k] <= count_d[k];
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
      afull_q   <= afull_d;
    end
  end

  // Token storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      srl_q[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) srl_q[i] <= srl_q[i-1];
    end
  end

  // Oldest token of channel k sits at slot count_k - 1.
  always_comb begin
    logic [CW-1:0] head_idx;
    if_dout = '0;
    for (int k = 0; k < NCH; k++) begin
      head_idx = (count_q[k] != '0) ? count_q[k] - CW'(1) : '0;
      if_dout[k*DATA_WIDTH +: DATA_WIDTH] = srl_q[0];
      for (int i = 0; i < DEPTH; i++) begin
        if (head_idx == CW'(i)) if_dout[k*DATA_WIDTH +: DATA_WIDTH] = srl_q[i];
      end
    end
  end

  always_comb begin
    if_count = '0;
    for (int k = 0; k < NCH; k++) if_count[k*CW +: CW] = count_q[k];
  end

  assign if_empty_n     = empty_n_q;
  assign if_full_n      = full_n_q;
  assign if_almost_full = afull_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NCH; k++) begin
        assert (count_q[k] <= CW'(DEPTH));
        assert (!(rd_en[k] && !wr_en && count_q[k] == '0));
      end
    end
  end

endmodule

// File: tb/tb_kernel_kcore_start_fork_fifo.sv
// tb/tb_kernel_kcore_start_fork_fifo.sv - directed bench for the start-token fork FIFO
module tb_kernel_kcore_start_fork_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       if_write_ce, if_write;
  logic [3:0] if_din;
  logic       if_full_n, if_almost_full;
  logic [1:0] if_read_ce, if_read, if_empty_n, chan_en;
  logic [7:0] if_dout;
  logic [5:0] if_count;

  int vec = 0;
  int err = 0;

  kernel_kcore_start_fork_fifo #(
    .DATA_WIDTH(4), .ADDR_WIDTH(2), .DEPTH(4), .NCH(2), .AFULL_THRESH(3)
  ) dut (
    .clk(clk), .reset(reset), .if_write_ce(if_write_ce), .if_write(if_write),
    .if_din(if_din), .if_full_n(if_full_n), .if_almost_full(if_almost_full),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_empty_n(if_empty_n),
    .if_dout(if_dout), .chan_en(chan_en), .if_count(if_count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] cnt(input int k);
    return if_count[k*3 +: 3];
  endfunction

  function automatic logic [3:0] dout(input int k);
    return if_dout[k*4 +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_write = 1'b0; if_write_ce = 1'b0; if_din = 4'h0;
    if_read = 2'b00; if_read_ce = 2'b00;
  endtask

  task automatic do_reset();
    idle();
    chan_en = 2'b11;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [3:0] d);
    if_write = 1'b1; if_write_ce = 1'b1; if_din = d;
    tick();
    if_write = 1'b0; if_write_ce = 1'b0;
  endtask

  task automatic test_reset();
    if_write = 1'b1; if_write_ce = 1'b1; if_din = 4'h7; chan_en = 2'b11;
    reset = 1'b1;
    tick();
    reset = 1'b0; idle();
    vec++; if (cnt(0) !== 3'd0) begin err++; $display("FAIL reset_count0 got %0d exp 0", cnt(0)); end
    vec++; if (cnt(1) !== 3'd0) begin err++; $display("FAIL reset_count1 got %0d exp 0", cnt(1)); end
    vec++; if (if_empty_n !== 2'b00) begin err++; $display("FAIL reset_empty_n got %b exp 00", if_empty_n); end
    vec++; if (if_full_n !== 1'b1) begin err++; $display("FAIL reset_full_n got %b exp 1", if_full_n); end
    vec++; if (if_almost_full !== 1'b0) begin err++; $display("FAIL reset_afull got %b exp 0", if_almost_full); end
  endtask

  task automatic test_fill();
    logic [2:0] exp_c;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      wr(4'h1);
      exp_c = 3'(i);
      vec++; if (cnt(0) !== exp_c || cnt(1) !== exp_c) begin err++; $display("FAIL fill_count w%0d got %0d/%0d exp %0d", i, cnt(0), cnt(1), exp_c); end
      vec++; if (if_almost_full !== (i >= 3)) begin err++; $display("FAIL fill_afull w%0d got %b exp %b", i, if_almost_full, (i >= 3)); end
      vec++; if (if_full_n !== (i < 4)) begin err++; $display("FAIL fill_full_n w%0d got %b exp %b", i, if_full_n, (i < 4)); end
      vec++; if (if_empty_n !== 2'b11) begin err++; $display("FAIL fill_empty_n w%0d got %b exp 11", i, if_empty_n); end
    end
    wr(4'hF);
    vec++; if (cnt(0) !== 3'd4 || cnt(1) !== 3'd4) begin err++; $display("FAIL fill_drop_count got %0d/%0d exp 4/4", cnt(0), cnt(1)); end
    vec++; if (dout(0) !== 4'h1 || dout(1) !== 4'h1) begin err++; $display("FAIL fill_drop_data got %h/%h exp 1/1", dout(0), dout(1)); end
  endtask

  task automatic test_drain();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'hA; exp_d[1] = 4'hB; exp_d[2] = 4'hC; exp_d[3] = 4'hD;
    do_reset();
    for (int i = 0; i < 4; i++) wr(exp_d[i]);
    wr(4'hE);
    vec++; if (cnt(1) !== 3'd4 || if_full_n !== 1'b0) begin err++; $display("FAIL drain_full got cnt %0d full_n %b exp 4 0", cnt(1), if_full_n); end
    vec++; if (dout(1) !== 4'hA) begin err++; $display("FAIL drain_nodrop got %h exp A", dout(1)); end
    if_read = 2'b01; if_read_ce = 2'b01;
    for (int i = 0; i < 4; i++) begin
      vec++; if (dout(0) !== exp_d[i]) begin err++; $display("FAIL drain_dout0 r%0d got %h exp %h", i, dout(0), exp_d[i]); end
      tick();
    end
    idle();
    vec++; if (if_empty_n !== 2'b10) begin err++; $display("FAIL drain_empty_n got %b exp 10", if_empty_n); end
    vec++; if (cnt(0) !== 3'd0 || cnt(1) !== 3'd4) begin err++; $display("FAIL drain_count got %0d/%0d exp 0/4", cnt(0), cnt(1)); end
    vec++; if (if_full_n !== 1'b0) begin err++; $display("FAIL drain_still_full got %b exp 0", if_full_n); end
    vec++; if (dout(1) !== 4'hA) begin err++; $display("FAIL drain_dout1 got %h exp A", dout(1)); end
    if_read = 2'b10; if_read_ce = 2'b10;
    tick();
    idle();
    vec++; if (if_full_n !== 1'b1 || cnt(1) !== 3'd3) begin err++; $display("FAIL drain_unfull got full_n %b cnt %0d exp 1 3", if_full_n, cnt(1)); end
    vec++; if (dout(1) !== 4'hB) begin err++; $display("FAIL drain_dout1_next got %h exp B", dout(1)); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_h [4];
    logic [2:0] exp_c0 [3];
    logic [2:0] exp_c1 [3];
    exp_h[0] = 4'h1; exp_h[1] = 4'h2; exp_h[2] = 4'h5; exp_h[3] = 4'h6;
    exp_c0[0] = 3'd2; exp_c0[1] = 3'd2; exp_c0[2] = 3'd1;
    exp_c1[0] = 3'd3; exp_c1[1] = 3'd4; exp_c1[2] = 3'd4;
    do_reset();
    wr(4'h1);
    wr(4'h2);
    for (int i = 0; i < 3; i++) begin
      vec++; if (dout(0) !== exp_h[i]) begin err++; $display("FAIL b2b_pop c%0d got %h exp %h", i, dout(0), exp_h[i]); end
      if_write = 1'b1; if_write_ce = 1'b1; if_din = 4'(5 + i);
      if_read = 2'b01; if_read_ce = 2'b01;
      tick();
      idle();
      vec++; if (cnt(0) !== exp_c0[i] || cnt(1) !== exp_c1[i]) begin err++; $display("FAIL b2b_count c%0d got %0d/%0d exp %0d/%0d", i, cnt(0), cnt(1), exp_c0[i], exp_c1[i]); end
    end
    vec++; if (if_full_n !== 1'b0) begin err++; $display("FAIL b2b_full_n got %b exp 0", if_full_n); end
    vec++; if (dout(0) !== exp_h[3] || dout(1) !== 4'h1) begin err++; $display("FAIL b2b_heads got %h/%h exp 6/1", dout(0), dout(1)); end
  endtask

  task automatic test_disable();
    do_reset();
    wr(4'h1); wr(4'h2); wr(4'h3);
    chan_en = 2'b01;
    if_read = 2'b10; if_read_ce = 2'b10;
    tick();
    idle();
    vec++; if (cnt(1) !== 3'd0 || if_empty_n !== 2'b01) begin err++; $display("FAIL dis_flush got cnt %0d empty_n %b exp 0 01", cnt(1), if_empty_n); end
    vec++; if (cnt(0) !== 3'd3 || if_almost_full !== 1'b1) begin err++; $display("FAIL dis_ch0 got cnt %0d afull %b exp 3 1", cnt(0), if_almost_full); end
    if_read = 2'b01; if_read_ce = 2'b01;
    tick(); tick(); tick();
    idle();
    for (int i = 0; i < 4; i++) wr(4'(8 + i));
    vec++; if (cnt(0) !== 3'd4 || cnt(1) !== 3'd0) begin err++; $display("FAIL dis_fill got %0d/%0d exp 4/0", cnt(0), cnt(1)); end
    vec++; if (if_full_n !== 1'b0 || if_empty_n !== 2'b01) begin err++; $display("FAIL dis_flags got full_n %b empty_n %b exp 0 01", if_full_n, if_empty_n); end
    vec++; if (dout(0) !== 4'h8) begin err++; $display("FAIL dis_head got %h exp 8", dout(0)); end
    chan_en = 2'b11;
    tick();
    vec++; if (cnt(1) !== 3'd0 || if_empty_n !== 2'b01) begin err++; $display("FAIL dis_reenable got cnt %0d empty_n %b exp 0 01", cnt(1), if_empty_n); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr(4'h1); wr(4'h2); wr(4'h3);
    if_read = 2'b10; if_read_ce = 2'b10;
    tick(); tick();
    idle();
    vec++; if (cnt(0) !== 3'd3 || cnt(1) !== 3'd1) begin err++; $display("FAIL mrst_pre got %0d/%0d exp 3/1", cnt(0), cnt(1)); end
    if_write = 1'b1; if_write_ce = 1'b1; if_din = 4'h9;
    if_read = 2'b01; if_read_ce = 2'b01;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    vec++; if (cnt(0) !== 3'd0 || cnt(1) !== 3'd0) begin err++; $display("FAIL mrst_count got %0d/%0d exp 0/0", cnt(0), cnt(1)); end
    vec++; if (if_empty_n !== 2'b00 || if_full_n !== 1'b1) begin err++; $display("FAIL mrst_flags got empty_n %b full_n %b exp 00 1", if_empty_n, if_full_n); end
    tick();
    vec++; if (cnt(0) !== 3'd0 || if_empty_n !== 2'b00) begin err++; $display("FAIL mrst_retain got cnt %0d empty_n %b exp 0 00", cnt(0), if_empty_n); end
  endtask

  task automatic test_ignored_reads();
    do_reset();
    if_read = 2'b11; if_read_ce = 2'b11;
    tick();
    idle();
    vec++; if (cnt(0) !== 3'd0 || cnt(1) !== 3'd0) begin err++; $display("FAIL ign_empty got %0d/%0d exp 0/0", cnt(0), cnt(1)); end
    wr(4'h4);
    if_read = 2'b11; if_read_ce = 2'b00;
    tick();
    idle();
    vec++; if (cnt(0) !== 3'd1 || cnt(1) !== 3'd1) begin err++; $display("FAIL ign_ce got %0d/%0d exp 1/1", cnt(0), cnt(1)); end
    vec++; if (dout(0) !== 4'h4 || if_empty_n !== 2'b11) begin err++; $display("FAIL ign_data got %h empty_n %b exp 4 11", dout(0), if_empty_n); end
  endtask

  initial begin
    reset = 1'b0;
    chan_en = 2'b11;
    idle();
    tick();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_disable();
    test_mid_reset();
    test_ignored_reads();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
